// File: rtl/led_blink_code_pkg.sv
// Shared types and elaboration helpers for the LED blink-code block.
package led_blink_code_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF,
    S_GAP
  } blink_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/led_blink_code_rise_strobe.sv
// One-clock strobe on each rising edge of a same-domain slow square wave.
module led_blink_code_rise_strobe (
  input  logic clock,
  input  logic reset_n,
  input  logic level_i,
  output logic strobe_o
);

  logic level_q;

  // Resetting to 1 keeps a level already high at reset release from strobing.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) level_q <= 1'b1;
    else          level_q <= level_i;
  end

  assign strobe_o = level_i & ~level_q;

endmodule

// File: rtl/led_blink_code.sv
// Blinks a status LED code_i times, then holds it dark for a long gap.
module led_blink_code
  import led_blink_code_pkg::*;
#(
  parameter int CODE_BITS = 4,
  parameter int ON_TICKS  = 1,
  parameter int OFF_TICKS = 1,
  parameter int GAP_TICKS = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 tick_i,
  input  logic [CODE_BITS-1:0] code_i,
  input  logic                 load_i,
  output logic                 busy_o,
  output logic                 led_o,
  output logic                 done_o
);

  localparam int PHASE_W = $clog2(max3(ON_TICKS, OFF_TICKS, GAP_TICKS) + 1);
  localparam logic [PHASE_W-1:0] ON_END  = PHASE_W'(ON_TICKS);
  localparam logic [PHASE_W-1:0] OFF_END = PHASE_W'(OFF_TICKS);
  localparam logic [PHASE_W-1:0] GAP_END = PHASE_W'(GAP_TICKS);

  if (CODE_BITS < 1 || ON_TICKS < 1 || OFF_TICKS < 1 || GAP_TICKS < 1) begin : g_param_err
    $error("led_blink_code: CODE_BITS and all TICKS parameters must be >= 1");
  end

  blink_state_t         state;
  logic [CODE_BITS-1:0] remaining;
  logic [CODE_BITS-1:0] remaining_dec;
  logic [PHASE_W-1:0]   phase;
  logic [PHASE_W-1:0]   phase_inc;
  logic                 phase_end;
  logic                 strobe;

  led_blink_code_rise_strobe u_rise (
    .clock    (clock),
    .reset_n  (reset_n),
    .level_i  (tick_i),
    .strobe_o (strobe)
  );

  assign phase_inc     = phase + PHASE_W'(1);
  assign remaining_dec = remaining - CODE_BITS'(1);
  assign busy_o        = (state != S_IDLE);

  always_comb begin
    phase_end = 1'b0;
    unique case (state)
      S_ON:    phase_end = (phase_inc == ON_END);
      S_OFF:   phase_end = (phase_inc == OFF_END);
      S_GAP:   phase_end = (phase_inc == GAP_END);
      default: phase_end = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      remaining <= '0;
      phase     <= '0;
      led_o     <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (load_i) begin
            remaining <= code_i;
            phase     <= '0;
            if (code_i != '0) begin
              state <= S_ON;
              led_o <= 1'b1;
            end else begin
              state <= S_GAP;
            end
          end
        end
        S_ON: begin
          if (strobe) begin
            if (phase_end) begin
              phase     <= '0;
              remaining <= remaining_dec;
              led_o     <= 1'b0;
              state     <= (remaining_dec != '0) ? S_OFF : S_GAP;
            end else begin
              phase <= phase_inc;
            end
          end
        end
        S_OFF: begin
          if (strobe) begin
            if (phase_end) begin
              phase <= '0;
              led_o <= 1'b1;
              state <= S_ON;
            end else begin
              phase <= phase_inc;
            end
          end
        end
        S_GAP: begin
          if (strobe) begin
            if (phase_end) begin
              phase  <= '0;
              done_o <= 1'b1;
              state  <= S_IDLE;
            end else begin
              phase <= phase_inc;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
